// File: rtl/ifu_prefetch.sv
// ifu_prefetch: owns the fetch PC, issues in-order instruction-memory
// requests, buffers responses in a DEPTH-entry prefetch queue for decode,
// and redirects/flushes on taken branches and jumps from execute.
// Optional feature macro: IFU_MISALIGN_TRAP_EN (adds fetch_misaligned and
// stops fetch on a misaligned redirect target).
module ifu_prefetch #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  output logic            dec_valid,
  input  logic            dec_ready,
  output logic [31:0]     dec_inst,
  output logic [XLEN-1:0] dec_pc,
  input  logic            ex_valid,
  input  logic [XLEN-1:0] ex_pc,
  input  logic            is_branch,
  input  logic            is_jmp,
  input  logic            jmp_reg,
  input  logic            eq,
  input  logic            lt,
  input  logic            ltu,
  input  logic [2:0]      fn3,
  input  logic [XLEN-1:0] alu_out,
  input  logic [XLEN-1:0] b_imm,
  input  logic [XLEN-1:0] j_imm,
  output logic            redirect
`ifdef IFU_MISALIGN_TRAP_EN
  ,
  output logic            fetch_misaligned
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int OW = CW + 1;

  // Queue bookkeeping: entries from head are first `count` filled ones,
  // followed by `inflight` allocated entries still waiting for data.
  logic [XLEN-1:0] fpc;
  logic [XLEN-1:0] q_pc   [DEPTH];
  logic [31:0]     q_inst [DEPTH];
  logic [PW-1:0]   head;
  logic [PW-1:0]   fill_ptr;
  logic [PW-1:0]   tail;
  logic [CW-1:0]   count;
  logic [CW-1:0]   inflight;
  logic [CW-1:0]   drop_cnt;
  logic [OW-1:0]   occupancy;

  logic            taken;
  logic [XLEN-1:0] raw_target;
  logic [XLEN-1:0] target;
  logic            fetch_stop;
  logic            req_fire;
  logic            rsp_fill;
  logic            rsp_drop;
  logic            pop;

  // Branch condition from funct3 and the comparator flags.
  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    taken = 1'b0;
    case (fn3)
      3'b000:  taken = eq;
      3'b001:  taken = ~eq;
      3'b100:  taken = lt;
      3'b101:  taken = ~lt;
      3'b110:  taken = ltu;
      3'b111:  taken = ~ltu;
      default: taken = 1'b0;
    endcase
  end

  // Redirect target; JALR clears bit 0, sums wrap modulo 2^XLEN.
  always_comb begin
    if (is_jmp && jmp_reg) raw_target = alu_out & ~XLEN'(1);
    else if (is_jmp)       raw_target = ex_pc + j_imm;
    else                   raw_target = ex_pc + b_imm;
  end

  assign redirect = ex_valid & (is_jmp | (is_branch & taken));

`ifdef IFU_MISALIGN_TRAP_EN
  assign target     = raw_target;
  assign fetch_stop = fetch_misaligned;
`else
  assign target     = raw_target & ~XLEN'(3);
  assign fetch_stop = 1'b0;
`endif

  // Unfilled entries already hold a queue slot, so they count once; pending
  // wrong-path responses still need a credit until they are discarded.
  assign occupancy      = OW'(count) + OW'(inflight) + OW'(drop_cnt);
  assign imem_req_valid = ~rst & ~redirect & ~fetch_stop & (occupancy < OW'(DEPTH));
  assign imem_req_addr  = fpc;

  assign req_fire = imem_req_valid & imem_req_ready;
  assign rsp_drop = imem_rsp_valid & (drop_cnt != '0);
  assign rsp_fill = imem_rsp_valid & (drop_cnt == '0) & ~redirect;

  assign fill_ptr = head + count[PW-1:0];
  assign tail     = fill_ptr + inflight[PW-1:0];

  assign dec_valid = (count != '0) & ~redirect;
  assign dec_inst  = q_inst[head];
  assign dec_pc    = q_pc[head];
  assign pop       = dec_valid & dec_ready;

  // Control state: fetch PC, queue occupancy, in-flight and drop tracking.
  // NOTE: sequential state uses <= so every register sees pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fpc      <= RESET_PC;
      head     <= '0;
      count    <= '0;
      inflight <= '0;
      drop_cnt <= '0;
`ifdef IFU_MISALIGN_TRAP_EN
      fetch_misaligned <= 1'b0;
`endif
    end else if (redirect) begin
`ifdef IFU_MISALIGN_TRAP_EN
      if (|target[1:0]) fetch_misaligned <= 1'b1;
      else              fpc              <= target;
`else
      fpc <= target;
`endif
      count    <= '0;
      inflight <= '0;
      // Everything still in flight becomes wrong-path, less the response
      // arriving right now (it is discarded with the flush).
      drop_cnt <= drop_cnt + inflight - CW'(imem_rsp_valid);
    end else begin
      if (req_fire) fpc  <= fpc + XLEN'(4);
      if (pop)      head <= head + PW'(1);
      count    <= count + CW'(rsp_fill) - CW'(pop);
      inflight <= inflight + CW'(req_fire) - CW'(rsp_fill);
      if (rsp_drop) drop_cnt <= drop_cnt - CW'(1);
    end
  end

  // Queue payload: PC written on request accept, instruction on response.
  // NOTE: payload arrays are not reset; count/inflight decide which entries are live.
  always_ff @(posedge clk) begin
    if (req_fire) q_pc[tail]       <= fpc;
    if (rsp_fill) q_inst[fill_ptr] <= imem_rsp_data;
  end

endmodule

// File: tb/tb_ifu_prefetch.sv
// Self-checking bench for ifu_prefetch: directed sequences, a redirect
// vector table, and randomized traffic against a queue-level reference model.
module tb_ifu_prefetch;

  localparam int          XLEN     = 32;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        dec_valid, dec_ready;
  logic [31:0] dec_inst, dec_pc;
  logic        ex_valid, is_branch, is_jmp, jmp_reg, eq, lt, ltu;
  logic [31:0] ex_pc, alu_out, b_imm, j_imm;
  logic [2:0]  fn3;
  logic        redirect;
`ifdef IFU_MISALIGN_TRAP_EN
  logic        fetch_misaligned;
`endif

  always #5 clk = ~clk;

  ifu_prefetch #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .dec_valid(dec_valid), .dec_ready(dec_ready),
    .dec_inst(dec_inst), .dec_pc(dec_pc),
    .ex_valid(ex_valid), .ex_pc(ex_pc),
    .is_branch(is_branch), .is_jmp(is_jmp), .jmp_reg(jmp_reg),
    .eq(eq), .lt(lt), .ltu(ltu), .fn3(fn3),
    .alu_out(alu_out), .b_imm(b_imm), .j_imm(j_imm),
    .redirect(redirect)
`ifdef IFU_MISALIGN_TRAP_EN
    , .fetch_misaligned(fetch_misaligned)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] addr;
    bit          stale;
    int          due;
  } mreq_t;

  mreq_t       mem_q[$];   // accepted requests awaiting a response
  logic [31:0] mq[$];      // PCs of queue entries, oldest first
  int          nfilled;    // how many of mq (from the front) hold data
  logic [31:0] exp_fpc;
  bit          trapped;
  int          cyc;
  int          lat_min = 1;
  int          lat_max = 1;

  bit          obs_fire, obs_dv, obs_redir, obs_rv;
  logic [31:0] obs_dpc, obs_addr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC0DE_1234;
  endfunction

  function automatic bit ref_taken(input logic [2:0] f, input bit e, input bit l, input bit lu);
    case (f)
      3'd0: return e;
      3'd1: return !e;
      3'd4: return l;
      3'd5: return !l;
      3'd6: return lu;
      3'd7: return !lu;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] ref_target();
    logic [31:0] t;
    if (is_jmp && jmp_reg) t = alu_out & 32'hFFFF_FFFE;
    else if (is_jmp)       t = ex_pc + j_imm;
    else                   t = ex_pc + b_imm;
`ifndef IFU_MISALIGN_TRAP_EN
    t = t & 32'hFFFF_FFFC;
`endif
    return t;
  endfunction

  task automatic reset_model();
    mq.delete();
    mem_q.delete();
    nfilled = 0;
    exp_fpc = RESET_PC;
    trapped = 0;
    cyc     = 0;
  endtask

  task automatic ex_idle();
    ex_valid = 0; is_branch = 0; is_jmp = 0; jmp_reg = 0;
    eq = 0; lt = 0; ltu = 0; fn3 = 3'd0;
    ex_pc = 0; alu_out = 0; b_imm = 0; j_imm = 0;
  endtask

  task automatic set_jal(input logic [31:0] pc, input logic [31:0] imm);
    ex_idle();
    ex_valid = 1; is_jmp = 1; ex_pc = pc; j_imm = imm;
  endtask

  task automatic rand_ex();
    ex_valid  = ($urandom_range(0, 99) < 8);
    is_branch = $urandom_range(0, 1);
    is_jmp    = ($urandom_range(0, 3) == 0);
    jmp_reg   = $urandom_range(0, 1);
    eq = $urandom_range(0, 1); lt = $urandom_range(0, 1); ltu = $urandom_range(0, 1);
    fn3 = 3'($urandom_range(0, 7));
    ex_pc = $urandom; alu_out = $urandom; b_imm = $urandom; j_imm = $urandom;
`ifdef IFU_MISALIGN_TRAP_EN
    ex_pc = ex_pc & 32'hFFFF_FFFC; b_imm = b_imm & 32'hFFFF_FFFC;
    j_imm = j_imm & 32'hFFFF_FFFC; alu_out = alu_out & 32'hFFFF_FFFD;
`endif
  endtask

  // Reset with rst held over two edges; outputs must be quiet immediately.
  task automatic do_reset();
    ex_idle();
    set_jal(32'h40, 32'h40);
    imem_rsp_valid = 0;
    rst = 1;
    #1;
    check("rst_req_valid", 32'(imem_req_valid), 32'd0);
    check("rst_dec_valid", 32'(dec_valid), 32'd0);
    ex_idle();
    @(negedge clk);
    @(negedge clk);
    rst = 0;
    reset_model();
  endtask

  // One clock: drive memory response, compare against the model, then
  // advance the model by the events of this cycle. Entered at a negedge.
  task automatic do_cycle();
    bit          rsp, redir, exp_rv, exp_dv, fire, pop;
    int          stale_n;
    logic [31:0] tgt;
    mreq_t       h;
    rsp = (mem_q.size() > 0) && (mem_q[0].due <= cyc);
    imem_rsp_valid = rsp;
    imem_rsp_data  = rsp ? mem_word(mem_q[0].addr) : $urandom;
    #1;
    redir   = ex_valid && (is_jmp || (is_branch && ref_taken(fn3, eq, lt, ltu)));
    tgt     = ref_target();
    stale_n = 0;
    foreach (mem_q[i]) if (mem_q[i].stale) stale_n++;
    exp_rv = !redir && !trapped && (mq.size() + stale_n < DEPTH);
    exp_dv = !redir && (nfilled > 0);
    check("redirect", 32'(redirect), 32'(redir));
    check("req_valid", 32'(imem_req_valid), 32'(exp_rv));
    if (exp_rv) check("req_addr", imem_req_addr, exp_fpc);
    check("dec_valid", 32'(dec_valid), 32'(exp_dv));
    if (exp_dv) begin
      check("dec_pc", dec_pc, mq[0]);
      check("dec_inst", dec_inst, mem_word(mq[0]));
    end
`ifdef IFU_MISALIGN_TRAP_EN
    check("misaligned", 32'(fetch_misaligned), 32'(trapped));
`endif
    obs_fire  = imem_req_valid && imem_req_ready;
    obs_dv    = dec_valid;
    obs_dpc   = dec_pc;
    obs_redir = redirect;
    obs_rv    = imem_req_valid;
    obs_addr  = imem_req_addr;
    fire = exp_rv && imem_req_ready;
    pop  = exp_dv && dec_ready;
    if (rsp) h = mem_q.pop_front();
    if (redir) begin
      foreach (mem_q[i]) mem_q[i].stale = 1'b1;
      mq.delete();
      nfilled = 0;
`ifdef IFU_MISALIGN_TRAP_EN
      if (tgt[1:0] != 2'b00) trapped = 1;
      else                   exp_fpc = tgt;
`else
      exp_fpc = tgt;
`endif
    end else begin
      if (pop) begin
        void'(mq.pop_front());
        nfilled--;
      end
      if (rsp && !h.stale) nfilled++;
      if (fire) begin
        mreq_t r;
        r.addr  = exp_fpc;
        r.stale = 1'b0;
        r.due   = cyc + $urandom_range(lat_max, lat_min);
        mem_q.push_back(r);
        mq.push_back(exp_fpc);
        exp_fpc = exp_fpc + 32'd4;
      end
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic run_until_dec(input string name, input int bound, input logic [31:0] exp_pc);
    bit          got;
    logic [31:0] pc;
    got = 0;
    pc  = '0;
    for (int k = 0; k < bound && !got; k++) begin
      do_cycle();
      if (obs_dv) begin
        got = 1;
        pc  = obs_dpc;
      end
    end
    check({name, "_timeout"}, 32'(got), 32'd1);
    if (got) check(name, pc, exp_pc);
  endtask

  // ---------------- redirect vector table ----------------
  typedef struct {
    bit          br, jmp, jr, feq, flt, fltu;
    logic [2:0]  f3;
    logic [31:0] pc, alu, bimm, jimm;
    bit          exp_redir;
    logic [31:0] exp_tgt;
  } vec_t;

  vec_t vecs[12];

  initial begin
    int          first_req, first_dec, n;
    logic [31:0] cur;

    vecs[0]  = '{1,0,0, 0,0,0, 3'd1, 32'h100, 32'h0, 32'hFFFF_FFF0, 32'h0, 1, 32'h0000_00F0}; // BNE taken
    vecs[1]  = '{0,1,1, 0,0,0, 3'd0, 32'h40, 32'h2001, 32'h0, 32'h0, 1, 32'h0000_2000};      // JALR
    vecs[2]  = '{1,0,0, 0,1,0, 3'd5, 32'h500, 32'h0, 32'h40, 32'h0, 0, 32'h0};               // BGE lt=1
    vecs[3]  = '{1,0,0, 1,0,0, 3'd0, 32'h40, 32'h0, 32'h20, 32'h0, 1, 32'h0000_0060};        // BEQ
    vecs[4]  = '{1,0,0, 1,1,0, 3'd6, 32'h80, 32'h0, 32'h8, 32'h0, 0, 32'h0};                 // BLTU ltu=0
    vecs[5]  = '{1,0,0, 0,0,0, 3'd7, 32'h1000, 32'h0, 32'h10, 32'h0, 1, 32'h0000_1010};      // BGEU
    vecs[6]  = '{1,0,0, 1,1,1, 3'd2, 32'h10, 32'h0, 32'h4, 32'h0, 0, 32'h0};                 // fn3=010
    vecs[7]  = '{0,1,0, 0,0,0, 3'd0, 32'hFFFF_FFF8, 32'h7, 32'h0, 32'h10, 1, 32'h0000_0008}; // JAL wrap
    vecs[8]  = '{1,0,0, 0,1,0, 3'd4, 32'h200, 32'h0, 32'h4, 32'h0, 1, 32'h0000_0204};        // BLT
    vecs[9]  = '{0,0,0, 1,1,1, 3'd0, 32'h300, 32'h0, 32'h40, 32'h40, 0, 32'h0};              // not a branch
    vecs[10] = '{1,0,0, 0,1,1, 3'd0, 32'h300, 32'h0, 32'h40, 32'h0, 0, 32'h0};               // BEQ eq=0
    vecs[11] = '{1,0,0, 1,0,0, 3'd3, 32'h300, 32'h0, 32'h40, 32'h0, 0, 32'h0};               // fn3=011

    ex_idle();
    imem_req_ready = 0; dec_ready = 0; imem_rsp_valid = 0; imem_rsp_data = 0;
    reset_model();
    #2 rst = 1;
    @(negedge clk);
    do_reset();

    // Sequential fetch with a 1-cycle memory and an always-ready decoder.
    imem_req_ready = 1; dec_ready = 1; lat_min = 1; lat_max = 1;
    first_req = -1; first_dec = -1;
    repeat (12) begin
      do_cycle();
      if (obs_fire && first_req < 0) first_req = cyc - 1;
      if (obs_dv && first_dec < 0)   first_dec = cyc - 1;
    end
    check("first_req_cycle", 32'(first_req), 32'd0);
    check("first_dec_latency", 32'(first_dec - first_req), 32'd2);

    // Decode stalled: the queue fills to DEPTH, then fetch stops until a pop.
    do_reset();
    imem_req_ready = 1; dec_ready = 0;
    n = 0;
    repeat (10) begin
      do_cycle();
      if (obs_fire) n++;
    end
    check("fill_accepts", 32'(n), 32'(DEPTH));
    check("full_req_valid", 32'(imem_req_valid), 32'd0);
    dec_ready = 1;
    do_cycle();
    check("full_pop", 32'(obs_dv), 32'd1);
    dec_ready = 0;
    do_cycle();
    check("resume_after_pop", 32'(obs_fire), 32'd1);
    dec_ready = 1;
    repeat (10) do_cycle();

    // Taken BNE with two requests in flight (3-cycle memory).
    do_reset();
    imem_req_ready = 1; dec_ready = 1; lat_min = 3; lat_max = 3;
    repeat (2) do_cycle();
    ex_valid = 1; is_branch = 1; fn3 = 3'd1; eq = 0;
    ex_pc = 32'h100; b_imm = 32'hFFFF_FFF0;
    do_cycle();
    check("bne_redirect", 32'(obs_redir), 32'd1);
    check("bne_no_req", 32'(obs_fire), 32'd0);
    ex_idle();
    do_cycle();
    check("bne_req_valid", 32'(obs_rv), 32'd1);
    check("bne_req_addr", obs_addr, 32'h0000_00F0);
    run_until_dec("bne_first_dec", 20, 32'h0000_00F0);
    repeat (10) do_cycle();

    // Table of redirect decodes; ready held low so fpc changes only on redirect.
    do_reset();
    imem_req_ready = 0; dec_ready = 0; lat_min = 1; lat_max = 1;
    cur = RESET_PC;
    for (int i = 0; i < 12; i++) begin
      ex_idle();
      ex_valid = 1;
      is_branch = vecs[i].br; is_jmp = vecs[i].jmp; jmp_reg = vecs[i].jr;
      eq = vecs[i].feq; lt = vecs[i].flt; ltu = vecs[i].fltu; fn3 = vecs[i].f3;
      ex_pc = vecs[i].pc; alu_out = vecs[i].alu; b_imm = vecs[i].bimm; j_imm = vecs[i].jimm;
      do_cycle();
      check($sformatf("vec%0d_redirect", i), 32'(obs_redir), 32'(vecs[i].exp_redir));
      if (vecs[i].exp_redir) cur = vecs[i].exp_tgt;
      ex_idle();
      #1;
      check($sformatf("vec%0d_fpc", i), imem_req_addr, cur);
      @(negedge clk);
      cyc++;
    end

    // Redirect while a response arrives, then a second redirect next cycle.
    do_reset();
    imem_req_ready = 1; dec_ready = 1; lat_min = 2; lat_max = 2;
    repeat (5) do_cycle();
    set_jal(32'h300, 32'h100);
    do_cycle();
    check("dbl_redirect1", 32'(obs_redir), 32'd1);
    set_jal(32'h800, 32'h80);
    do_cycle();
    check("dbl_redirect2", 32'(obs_redir), 32'd1);
    ex_idle();
    run_until_dec("dbl_first_dec", 20, 32'h0000_0880);
    repeat (15) do_cycle();

    // Randomized traffic against the model, with occasional resets.
    do_reset();
    lat_min = 1; lat_max = 4;
    for (int i = 0; i < 3000; i++) begin
      imem_req_ready = ($urandom_range(0, 3) != 0);
      dec_ready      = ($urandom_range(0, 9) < 7);
      rand_ex();
      if ($urandom_range(0, 599) == 0) do_reset();
      else                             do_cycle();
    end
    ex_idle();

`ifdef IFU_MISALIGN_TRAP_EN
    // Misaligned JAL target: trap sticks, fetch stops until reset.
    do_reset();
    imem_req_ready = 1; dec_ready = 1; lat_min = 1; lat_max = 1;
    repeat (3) do_cycle();
    set_jal(32'h100, 32'h2);
    do_cycle();
    ex_idle();
    check("trap_set", 32'(fetch_misaligned), 32'd1);
    n = 0;
    repeat (6) begin
      do_cycle();
      if (obs_fire) n++;
    end
    check("trap_no_requests", 32'(n), 32'd0);
    do_reset();
    #1;
    check("trap_cleared", 32'(fetch_misaligned), 32'd0);
    check("restart_valid", 32'(imem_req_valid), 32'd1);
    check("restart_addr", imem_req_addr, RESET_PC);
    @(negedge clk);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
